accel_interconnect: RTL and testbench

Parametrised accelerator interconnect between the CPU accelerator port and up to NUM_ACCELS accelerator adapters. It decodes accel_id, muxes per-slave can_read/can_write/read_data back to the CPU, and gates enables so a slave only sees a transfer it has accepted. Id 0 is an internal event controller that generalises the single swap flag to NUM_EVENTS maskable, latched event lines. A stall watchdog flags CPU accesses that wait too long on a slave.

---
 rtl/accel_pkg.sv | 29 ++
 rtl/accel_event_ctrl.sv | 78 +++++++
 rtl/accel_interconnect.sv | 151 +++++++++++++++
 tb/tb_accel_interconnect.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
// Shared ids and helpers for the accelerator interconnect and its event controller.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package accel_pkg;

  // Well-known slave slots on the accelerator port. Slot 0 is the internal
  // event controller; the rest are external adapters.
  typedef enum logic [3:0] {
    ACCEL_ID_EVENT    = 4'd0,
    ACCEL_ID_LINE     = 4'd1,
    ACCEL_ID_FILL     = 4'd2,
    ACCEL_ID_SYMBOL   = 4'd3,
    ACCEL_ID_KEYBOARD = 4'd4,
    ACCEL_ID_ALU      = 4'd5,
    ACCEL_ID_SM       = 4'd6,
    ACCEL_ID_FIFO     = 4'd7
  } accel_id_e;

  // Event read data carries a valid flag in its top bit.
  function automatic int unsigned evt_valid_bit(input int unsigned data_width);
    return data_width - 1;
  endfunction

  // Width of an index into n lines (at least one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/accel_event_ctrl.sv
// Event controller in slot 0: latched, maskable event lines with a lowest-index priority encoder.
// Latency: read data/can_read are combinational from the registers; set/clear/mask updates land on the next clk edge.
// Backpressure: can_read low when no unmasked event is pending; writes are always accepted.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   event_i           single-cycle event pulses, one per line
//   rd_req_i          CPU read on slot 0 (qualified here by can_read)
//   wr_req_i          CPU write on slot 0; loads mask from mask_wr_i
//   mask_wr_i         new mask value
//   can_read_o        an unmasked event is pending
//   read_data_o       {valid, zero pad, lowest pending unmasked index}, 0 when none
module accel_event_ctrl
  import accel_pkg::*;
#(
  parameter int unsigned NUM_EVENTS = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned EVENT_INIT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_EVENTS-1:0] event_i,
  input  logic                  rd_req_i,
  input  logic                  wr_req_i,
  input  logic [NUM_EVENTS-1:0] mask_wr_i,
  output logic                  can_read_o,
  output logic [DATA_WIDTH-1:0] read_data_o
);

  localparam int unsigned IDX_W   = idx_width(NUM_EVENTS);
  localparam int unsigned VLD_BIT = evt_valid_bit(DATA_WIDTH);
  localparam logic [NUM_EVENTS-1:0] INIT_VEC = NUM_EVENTS'(EVENT_INIT);

  logic [NUM_EVENTS-1:0] pending_q, pending_d;
  logic [NUM_EVENTS-1:0] mask_q, mask_d;
  logic [NUM_EVENTS-1:0] active;
  logic [NUM_EVENTS-1:0] lowest;
  logic [NUM_EVENTS-1:0] clr;
  logic [IDX_W-1:0]      idx;
  logic                  any;

  always_comb begin
    active = pending_q & mask_q;
    any    = |active;

    // Scan high to low so the lowest set bit is the last one written.
    idx = '0;
    for (int k = NUM_EVENTS - 1; k >= 0; k--) begin
      if (active[k]) idx = IDX_W'(k);
    end

    // Isolate the lowest set bit: the one a read consumes.
    lowest = active & (~active + NUM_EVENTS'(1));
    clr    = rd_req_i ? lowest : '0;

    // OR the new events in after the clear so a coincident set wins.
    pending_d = (pending_q & ~clr) | event_i;
    mask_d    = wr_req_i ? mask_wr_i : mask_q;

    read_data_o = '0;
    if (any) begin
      read_data_o[VLD_BIT]     = 1'b1;
      read_data_o[IDX_W-1:0]   = idx;
    end
    can_read_o = any;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= INIT_VEC;
      mask_q    <= '1;
    end else begin
      pending_q <= pending_d;
      mask_q    <= mask_d;
    end
  end

endmodule

// File: rtl/accel_interconnect.sv
// Accelerator interconnect: decodes accel_id, muxes slave ready/data to the CPU, gates strobes, hosts the event controller and a stall watchdog.
// Latency: data path zero-cycle combinational; stall_irq/stall_id registered (one cycle after the limit-reaching wait cycle).
// Backpressure: the selected slave's can_read/can_write pass straight through; strobes reach a slave only when it is ready.
//
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   accel_id                            CPU-selected slave slot
//   accel_read_enable/write_enable      CPU transfer strobes
//   accel_write_data                    CPU write data (broadcast on slv_write_data)
//   accel_wait                          CPU stalled on an accelerator op this cycle
//   accel_can_read/can_write/read_data  selected slave status and data back to the CPU
//   slv_can_read/can_write/read_data    per-slave status and data (slot 0 ignored)
//   slv_read_enable/write_enable        gated per-slave strobes (bit 0 tied low)
//   event_in                            event pulses into the slot-0 controller
//   stall_irq, stall_id                 watchdog pulse and the id that stalled
module accel_interconnect
  import accel_pkg::*;
#(
  parameter int unsigned NUM_ACCELS  = 8,
  parameter int unsigned ID_WIDTH    = 4,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned NUM_EVENTS  = 4,
  parameter int unsigned EVENT_INIT  = 1,
  parameter int unsigned STALL_LIMIT = 1024
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [ID_WIDTH-1:0]              accel_id,
  input  logic                             accel_read_enable,
  input  logic                             accel_write_enable,
  input  logic [DATA_WIDTH-1:0]            accel_write_data,
  input  logic                             accel_wait,
  output logic                             accel_can_read,
  output logic                             accel_can_write,
  output logic [DATA_WIDTH-1:0]            accel_read_data,
  input  logic [NUM_ACCELS-1:0]            slv_can_read,
  input  logic [NUM_ACCELS-1:0]            slv_can_write,
  input  logic [NUM_ACCELS*DATA_WIDTH-1:0] slv_read_data,
  output logic [NUM_ACCELS-1:0]            slv_read_enable,
  output logic [NUM_ACCELS-1:0]            slv_write_enable,
  output logic [DATA_WIDTH-1:0]            slv_write_data,
  input  logic [NUM_EVENTS-1:0]            event_in,
  output logic                             stall_irq,
  output logic [ID_WIDTH-1:0]              stall_id
);

  localparam int unsigned CNT_W = $clog2(STALL_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(STALL_LIMIT - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(STALL_LIMIT);

  // ---------------------------------------------------------------------------
  // Slot 0: event controller
  // ---------------------------------------------------------------------------
  logic                  evt_sel;
  logic                  evt_can_read;
  logic [DATA_WIDTH-1:0] evt_read_data;

  assign evt_sel = (accel_id == ID_WIDTH'(ACCEL_ID_EVENT));

  accel_event_ctrl #(
    .NUM_EVENTS (NUM_EVENTS),
    .DATA_WIDTH (DATA_WIDTH),
    .EVENT_INIT (EVENT_INIT)
  ) u_event_ctrl (
    .clk         (clk),
    .rst_n       (rst_n),
    .event_i     (event_in),
    .rd_req_i    (evt_sel & accel_read_enable),
    .wr_req_i    (evt_sel & accel_write_enable),
    .mask_wr_i   (accel_write_data[NUM_EVENTS-1:0]),
    .can_read_o  (evt_can_read),
    .read_data_o (evt_read_data)
  );

  // ---------------------------------------------------------------------------
  // Decode and mux. Ids at or beyond NUM_ACCELS match nothing and fall
  // through to the all-zero defaults.
  // ---------------------------------------------------------------------------
  always_comb begin
    accel_can_read   = 1'b0;
    accel_can_write  = 1'b0;
    accel_read_data  = '0;
    slv_read_enable  = '0;
    slv_write_enable = '0;

    if (evt_sel) begin
      accel_can_read  = evt_can_read;
      accel_can_write = 1'b1;
      accel_read_data = evt_read_data;
    end

    for (int i = 1; i < NUM_ACCELS; i++) begin
      if (accel_id == ID_WIDTH'(i)) begin
        accel_can_read      = slv_can_read[i];
        accel_can_write     = slv_can_write[i];
        accel_read_data     = slv_read_data[i*DATA_WIDTH +: DATA_WIDTH];
        // A slave only sees a strobe for a transfer it is ready to accept.
        slv_read_enable[i]  = accel_read_enable & slv_can_read[i];
        slv_write_enable[i] = accel_write_enable & slv_can_write[i];
      end
    end
  end

  assign slv_write_data = accel_write_data;

  // Slot 0 of the slave-side inputs belongs to the internal controller.
  logic unused_slot0;
  assign unused_slot0 = ^{slv_can_read[0], slv_can_write[0], slv_read_data[DATA_WIDTH-1:0]};

  // ---------------------------------------------------------------------------
  // Stall watchdog. A wait cycle only extends the run if the id matches the
  // previous cycle's id, so a wait cycle on a freshly changed id restarts the
  // count from zero rather than counting as the first cycle of the run.
  // The counter saturates one past the fire point so the pulse cannot repeat
  // until the run is broken.
  // ---------------------------------------------------------------------------
  logic [ID_WIDTH-1:0] prev_id_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                stall_irq_q, stall_irq_d;
  logic [ID_WIDTH-1:0] stall_id_q, stall_id_d;
  logic                stall_run;

  always_comb begin
    stall_run = accel_wait & (accel_id == prev_id_q);

    if (!stall_run)            cnt_d = '0;
    else if (cnt_q == CNT_SAT) cnt_d = cnt_q;
    else                       cnt_d = cnt_q + CNT_W'(1);

    stall_irq_d = stall_run & (cnt_q == CNT_FIRE);
    stall_id_d  = stall_irq_d ? accel_id : stall_id_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_id_q   <= '0;
      cnt_q       <= '0;
      stall_irq_q <= 1'b0;
      stall_id_q  <= '0;
    end else begin
      prev_id_q   <= accel_id;
      cnt_q       <= cnt_d;
      stall_irq_q <= stall_irq_d;
      stall_id_q  <= stall_id_d;
    end
  end

  assign stall_irq = stall_irq_q;
  assign stall_id  = stall_id_q;

endmodule

// File: tb/tb_accel_interconnect.sv
// Bench for accel_interconnect: event controller sequences, table-driven mux vectors, watchdog runs.
// Expectations are pushed to a scoreboard queue at drive time and popped at the sample point.
module tb_accel_interconnect;

  localparam int NA = 8;
  localparam int IW = 4;
  localparam int DW = 16;
  localparam int NE = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [IW-1:0]    accel_id = '0;
  logic             accel_read_enable = 1'b0;
  logic             accel_write_enable = 1'b0;
  logic [DW-1:0]    accel_write_data = '0;
  logic             accel_wait = 1'b0;
  logic             accel_can_read, accel_can_write;
  logic [DW-1:0]    accel_read_data;
  logic [NA-1:0]    slv_can_read = '0;
  logic [NA-1:0]    slv_can_write = '0;
  logic [NA*DW-1:0] slv_read_data;
  logic [NA-1:0]    slv_read_enable, slv_write_enable;
  logic [DW-1:0]    slv_write_data;
  logic [NE-1:0]    event_in = '0;
  logic             stall_irq;
  logic [IW-1:0]    stall_id;

  accel_interconnect #(
    .NUM_ACCELS(NA), .ID_WIDTH(IW), .DATA_WIDTH(DW),
    .NUM_EVENTS(NE), .EVENT_INIT(1), .STALL_LIMIT(1024)
  ) dut (
    .clk(clk), .rst_n(rst_n), .accel_id(accel_id),
    .accel_read_enable(accel_read_enable), .accel_write_enable(accel_write_enable),
    .accel_write_data(accel_write_data), .accel_wait(accel_wait),
    .accel_can_read(accel_can_read), .accel_can_write(accel_can_write),
    .accel_read_data(accel_read_data),
    .slv_can_read(slv_can_read), .slv_can_write(slv_can_write),
    .slv_read_data(slv_read_data),
    .slv_read_enable(slv_read_enable), .slv_write_enable(slv_write_enable),
    .slv_write_data(slv_write_data), .event_in(event_in),
    .stall_irq(stall_irq), .stall_id(stall_id)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];
  int  n_pass  = 0;
  int  n_total = 0;

  task automatic sb_push(input string name, input logic [31:0] exp);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input logic [31:0] act);
    sb_t e;
    n_total++;
    if (sb_q.size() == 0) begin
      $display("FAIL scoreboard_empty: got 0x%0h with no expectation queued", act);
    end else begin
      e = sb_q.pop_front();
      if (act === e.exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- mux vector table ----------------
  typedef struct {
    logic [IW-1:0] id;
    logic          re, we;
    logic [NA-1:0] scr, scw;
    logic [DW-1:0] wd;
    logic          e_cr, e_cw;
    logic [DW-1:0] e_rd;
    logic [NA-1:0] e_sre, e_swe;
  } vec_t;
  vec_t vecs[10];

  // ---------------- watchdog run ----------------
  // Cycles 1..n: accel_wait high for k <= wait_last, id switches from id_a
  // to id_b at switch_at, an async reset pulse hits cycle rst_at (0 = none).
  task automatic run_wd(input int n, input int wait_last, input int id_a, input int id_b,
                        input int switch_at, input int rst_at,
                        output int pulses, output int first);
    pulses = 0;
    first  = 0;
    for (int k = 1; k <= n; k++) begin
      accel_wait = (k <= wait_last);
      accel_id   = (k >= switch_at) ? IW'(id_b) : IW'(id_a);
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      @(negedge clk);
      if (stall_irq) begin
        pulses++;
        if (first == 0) first = k;
      end
      tick();
    end
  endtask

  int pulses, first;

  initial begin
    for (int i = 0; i < NA; i++) slv_read_data[i*DW +: DW] = DW'(i * 16'h1111);
    slv_read_data[0*DW +: DW] = 16'hDEAD;
    slv_read_data[5*DW +: DW] = 16'h1234;

    vecs[0] = '{4'd5,  1'b1, 1'b0, 8'h00, 8'h00, 16'h0000, 1'b0, 1'b0, 16'h1234, 8'h00, 8'h00};
    vecs[1] = '{4'd5,  1'b1, 1'b0, 8'h20, 8'h00, 16'h0000, 1'b1, 1'b0, 16'h1234, 8'h20, 8'h00};
    vecs[2] = '{4'd5,  1'b1, 1'b1, 8'hFF, 8'hDF, 16'hBEEF, 1'b1, 1'b0, 16'h1234, 8'h20, 8'h00};
    vecs[3] = '{4'd3,  1'b0, 1'b1, 8'h00, 8'h08, 16'hA5A5, 1'b0, 1'b1, 16'h3333, 8'h00, 8'h08};
    vecs[4] = '{4'd3,  1'b1, 1'b1, 8'hF7, 8'hF7, 16'h0F0F, 1'b0, 1'b0, 16'h3333, 8'h00, 8'h00};
    vecs[5] = '{4'd9,  1'b1, 1'b1, 8'hFF, 8'hFF, 16'h5555, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00};
    vecs[6] = '{4'd7,  1'b1, 1'b0, 8'hFF, 8'h00, 16'h0000, 1'b1, 1'b0, 16'h7777, 8'h80, 8'h00};
    vecs[7] = '{4'd15, 1'b1, 1'b1, 8'hFF, 8'hFF, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00};
    vecs[8] = '{4'd1,  1'b1, 1'b1, 8'h02, 8'h02, 16'h1357, 1'b1, 1'b1, 16'h1111, 8'h02, 8'h02};
    vecs[9] = '{4'd0,  1'b1, 1'b0, 8'hFF, 8'hFF, 16'h00AA, 1'b0, 1'b1, 16'h0000, 8'h00, 8'h00};

    // ---- async reset: outputs follow reset state before any clock edge ----
    #1 rst_n = 1'b0;
    #2;
    sb_push("rst_can_read", 1);      sb_check(accel_can_read);
    sb_push("rst_read_data", 16'h8000); sb_check(accel_read_data);
    sb_push("rst_can_write", 1);     sb_check(accel_can_write);
    sb_push("rst_stall_irq", 0);     sb_check(stall_irq);
    sb_push("rst_stall_id", 0);      sb_check(stall_id);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // ---- initial event read clears it ----
    accel_read_enable = 1'b1;
    sb_push("t1_can_read", 1); sb_push("t1_rd", 16'h8000); sb_push("t1_slv_re0", 0);
    @(negedge clk);
    sb_check(accel_can_read); sb_check(accel_read_data); sb_check(slv_read_enable);
    tick();
    accel_read_enable = 1'b0;
    sb_push("t1_can_read_after", 0); sb_push("t1_rd_after", 0);
    @(negedge clk);
    sb_check(accel_can_read); sb_check(accel_read_data);

    // ---- two events, read lowest first ----
    tick();
    event_in = 4'b1010;
    sb_push("t2_not_yet", 0);
    @(negedge clk); sb_check(accel_can_read);
    tick();
    event_in = '0;
    accel_read_enable = 1'b1;
    sb_push("t2_can_read", 1); sb_push("t2_rd1", 16'h8001);
    @(negedge clk); sb_check(accel_can_read); sb_check(accel_read_data);
    tick();
    sb_push("t2_rd3", 16'h8003);
    @(negedge clk); sb_check(accel_read_data);
    tick();
    accel_read_enable = 1'b0;
    sb_push("t2_empty", 0);
    @(negedge clk); sb_check(accel_can_read);

    // ---- mask write hides pending events ----
    tick();
    event_in = 4'b0011;
    tick();
    event_in = '0;
    accel_write_enable = 1'b1;
    accel_write_data = 16'h0004;
    sb_push("t3_can_write", 1); sb_push("t3_pre_mask_cr", 1); sb_push("t3_pre_mask_rd", 16'h8000);
    @(negedge clk); sb_check(accel_can_write); sb_check(accel_can_read); sb_check(accel_read_data);
    tick();
    accel_write_enable = 1'b0;
    sb_push("t3_masked_cr", 0); sb_push("t3_masked_rd", 0);
    @(negedge clk); sb_check(accel_can_read); sb_check(accel_read_data);
    tick();
    event_in = 4'b0100;
    tick();
    event_in = '0;
    accel_read_enable = 1'b1;
    sb_push("t3_ev2_cr", 1); sb_push("t3_ev2_rd", 16'h8002);
    @(negedge clk); sb_check(accel_can_read); sb_check(accel_read_data);
    tick();
    accel_read_enable = 1'b0;
    sb_push("t3_ev2_cleared", 0);
    @(negedge clk); sb_check(accel_can_read);
    tick();
    accel_write_enable = 1'b1;
    accel_write_data = 16'h000F;
    tick();
    accel_write_enable = 1'b0;
    sb_push("t3_unmask_cr", 1); sb_push("t3_unmask_rd", 16'h8000);
    @(negedge clk); sb_check(accel_can_read); sb_check(accel_read_data);

    // ---- set and clear on the same bit: set wins ----
    tick();
    accel_read_enable = 1'b1;
    tick();
    event_in = 4'b0010;
    sb_push("t4_rd1", 16'h8001);
    @(negedge clk); sb_check(accel_read_data);
    tick();
    event_in = '0;
    accel_read_enable = 1'b0;
    sb_push("t4_set_wins_cr", 1); sb_push("t4_set_wins_rd", 16'h8001);
    @(negedge clk); sb_check(accel_can_read); sb_check(accel_read_data);
    tick();
    accel_read_enable = 1'b1;
    tick();
    accel_read_enable = 1'b0;
    sb_push("t4_drained", 0);
    @(negedge clk); sb_check(accel_can_read);
    tick();

    // ---- mux / strobe gating vectors ----
    for (int v = 0; v < 10; v++) begin
      accel_id           = vecs[v].id;
      accel_read_enable  = vecs[v].re;
      accel_write_enable = vecs[v].we;
      slv_can_read       = vecs[v].scr;
      slv_can_write      = vecs[v].scw;
      accel_write_data   = vecs[v].wd;
      sb_push($sformatf("v%0d_can_read", v),  vecs[v].e_cr);
      sb_push($sformatf("v%0d_can_write", v), vecs[v].e_cw);
      sb_push($sformatf("v%0d_read_data", v), vecs[v].e_rd);
      sb_push($sformatf("v%0d_slv_re", v),    vecs[v].e_sre);
      sb_push($sformatf("v%0d_slv_we", v),    vecs[v].e_swe);
      sb_push($sformatf("v%0d_slv_wd", v),    vecs[v].wd);
      @(negedge clk);
      sb_check(accel_can_read);  sb_check(accel_can_write); sb_check(accel_read_data);
      sb_check(slv_read_enable); sb_check(slv_write_enable); sb_check(slv_write_data);
      tick();
    end
    accel_read_enable = 1'b0;
    accel_write_enable = 1'b0;
    slv_can_read = '0;
    slv_can_write = '0;

    // ---- watchdog ----
    accel_id = 4'd9;
    tick(); tick();

    run_wd(1030, 1024, 9, 9, 1 << 30, 0, pulses, first);
    sb_push("wd1_pulses", 1);  sb_check(pulses);
    sb_push("wd1_first", 1025); sb_check(first);
    sb_push("wd1_stall_id", 9); sb_check(stall_id);

    run_wd(1510, 1500, 9, 9, 1 << 30, 0, pulses, first);
    sb_push("wd2_saturate_pulses", 1); sb_check(pulses);
    sb_push("wd2_first", 1025);        sb_check(first);

    run_wd(2010, 2000, 9, 10, 1001, 0, pulses, first);
    sb_push("wd3_id_change_pulses", 0); sb_check(pulses);
    sb_push("wd3_stall_id_held", 9);    sb_check(stall_id);

    run_wd(1100, 1100, 9, 9, 1 << 30, 1000, pulses, first);
    sb_push("wd4_reset_pulses", 0);  sb_check(pulses);
    sb_push("wd4_stall_id_rst", 0);  sb_check(stall_id);

    // Reset also restored the event controller.
    accel_wait = 1'b0;
    accel_id = 4'd0;
    sb_push("wd4_evt_cr", 1); sb_push("wd4_evt_rd", 16'h8000);
    @(negedge clk); sb_check(accel_can_read); sb_check(accel_read_data);

    if (sb_q.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
